seven_seg_scroll_driver: RTL and testbench
==========================================

SEVEN_SEG_SCROLL_DRIVER -- requirements
Module: seven_seg_scroll_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL have parameter BUF_DEPTH, default 16, character buffer entries (legal NUM_DIGITS..32).
REQ-003 The block SHALL have parameter REFRESH_DIV, default 50000, clk cycles each digit is driven (legal >=2).
REQ-004 The block SHALL have parameter SCROLL_DIV, default 25000000, clk cycles per scroll step (legal >=2).
REQ-005 The block SHALL have the port clk, input, 1, sole clock, rising edge.
REQ-006 The block SHALL have the port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have the port wr_en, input, 1, append wr_char to the buffer this cycle.
REQ-008 The block SHALL have the port wr_char, input, 5, character code: 0..25 = A..Z, 26..31 = blank.
REQ-009 The block SHALL have the port clear, input, 1, empty the buffer.
REQ-010 The block SHALL have the port scroll_en, input, 1, 1 = scroll mode, 0 = static mode.
REQ-011 The block SHALL have the port buf_full, output, 1, high when count == BUF_DEPTH.
REQ-012 The block SHALL have the port char_count, output, 6, number of stored characters.
REQ-013 The block SHALL have the port seg, output, 7, active-low segments {g,f,e,d,c,b,a}, registered.
REQ-014 The block SHALL have the port an, output, NUM_DIGITS, active-low digit enables, one-hot-low, registered; an[0] = leftmost digit.

Function
REQ-015 Buffer write SHALL occur when wr_en=1, clear=0 and count<BUF_DEPTH: store at index count, count+1 next cycle.
REQ-016 wr_en while full SHALL be dropped: buffer and count unchanged.
REQ-017 clear=1 SHALL set count=0 and offset=0 next cycle; clear wins over a simultaneous wr_en.
REQ-018 Refresh counter SHALL count 0..REFRESH_DIV-1; at terminal count digit select p advances, NUM_DIGITS-1 wraps to 0.
REQ-019 Digit position p SHALL display buffer index idx = offset + p; idx >= count SHALL display blank (1111111).
REQ-020 Glyphs (seg hex, active-low) SHALL be: A08 B03 C46 D21 E06 F0E G10 H0B I79 J71 K0E L47 M54 N15 O40 P0C Q08 R1F S12 T07 U41 V61 W50 X37 Y11 Z24; codes 26..31 = 7F.
REQ-021 seg and an SHALL be registered with 1-cycle latency from p, offset, count and buffer contents.
REQ-022 an SHALL have exactly bit p low at all times after the first post-reset cycle.
REQ-023 Static mode (scroll_en=0): offset SHALL be held at 0; scroll divider held at 0.
REQ-024 Scroll mode: scroll divider SHALL count 0..SCROLL_DIV-1; at terminal count, if count > NUM_DIGITS, offset increments.
REQ-025 Scroll wrap: when offset == count-NUM_DIGITS at a scroll step, offset SHALL become 0.
REQ-026 count <= NUM_DIGITS in scroll mode SHALL hold offset at 0.
REQ-027 A write during scroll mode SHALL be accepted; the new length applies from the next scroll step.
REQ-028 scroll_en 1->0 SHALL force offset=0 and scroll divider=0 the next cycle; 0->1 starts divider from 0.
REQ-029 buf_full and char_count SHALL be combinational from count.

Reset
REQ-030 rst SHALL clear count, offset, p, refresh and scroll counters to 0; buffer contents need not clear.
REQ-031 During rst, seg SHALL be 1111111 and an all ones; rst dominates wr_en and clear.
REQ-032 First cycle after rst release SHALL show an = ~1 (digit 0) with seg = 1111111.

Verification (NUM_DIGITS=4, BUF_DEPTH=8, REFRESH_DIV=4, SCROLL_DIV=32)
REQ-033 Reset then idle 20 cycles -> an walks 1110,1101,1011,0111 every 4 cycles; seg always 7F.
REQ-034 Write H,E,L,P (7,4,11,15), static -> digits 0..3 show 0B,06,47,0C; char_count=4.
REQ-035 Write 9 chars with wr_en held -> 8 accepted, buf_full=1, char_count=8, 9th dropped.
REQ-036 Write A..F (6 chars), scroll_en=1 -> offset 0,1,2,0 at 32-cycle steps; digit 0 shows 08,03,46,08.
REQ-037 clear and wr_en asserted together with count=5 -> count=0, all digits blank next refresh.
REQ-038 rst asserted mid-scroll with offset=2 -> next cycle offset=0, p=0, an=all ones, seg=7F.

Source files
------------

// File: rtl/seven_seg_scroll_driver.sv
// Seven-segment scrolling text driver.
// Characters (A..Z, blank) are appended to a small buffer and shown on
// NUM_DIGITS multiplexed active-low digits. In scroll mode the visible window
// slides one character per SCROLL_DIV cycles and wraps back to the start.
module seven_seg_scroll_driver #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned BUF_DEPTH   = 16,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned SCROLL_DIV  = 25000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [4:0]            wr_char,
   input  logic                  clear,
   input  logic                  scroll_en,
   output logic                  buf_full,
   output logic [5:0]            char_count,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] an
);

   localparam int unsigned PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned RW = $clog2(REFRESH_DIV);
   localparam int unsigned SW = $clog2(SCROLL_DIV);
   localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   localparam logic [5:0]    DEPTH6   = 6'(BUF_DEPTH);
   localparam logic [5:0]    ND6      = 6'(NUM_DIGITS);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [SW-1:0] SCR_LAST = SW'(SCROLL_DIV - 1);
   localparam logic [PW-1:0] P_LAST   = PW'(NUM_DIGITS - 1);
   localparam logic [6:0]    BLANK    = 7'h7F;

   logic [4:0]            r_buf [2**AW];
   logic [5:0]            r_count;
   logic [5:0]            r_offset;
   logic [SW-1:0]         r_scroll;
   logic [RW-1:0]         r_refresh;
   logic [PW-1:0]         r_p;
   logic [6:0]            r_seg;
   logic [NUM_DIGITS-1:0] r_an;

   logic                  w_wr_accept;
   logic                  w_scroll_step;
   logic [5:0]            w_idx;
   logic                  w_blank;
   logic [4:0]            w_code;
   logic [6:0]            w_glyph;
   logic [NUM_DIGITS-1:0] w_an_next;

   assign w_wr_accept   = wr_en & ~clear & ~rst & (r_count < DEPTH6);
   assign w_scroll_step = scroll_en & (r_scroll == SCR_LAST);
   assign w_idx         = r_offset + {{(6 - PW){1'b0}}, r_p};
   assign w_blank       = (w_idx >= r_count);
   assign w_code        = r_buf[w_idx[AW-1:0]];

   assign buf_full   = (r_count == DEPTH6);
   assign char_count = r_count;
   assign seg        = r_seg;
   assign an         = r_an;

   // Character storage; contents survive reset, only count defines validity.
   always_ff @(posedge clk) begin
      if (w_wr_accept) begin
         r_buf[r_count[AW-1:0]] <= wr_char;
      end
   end

   // Buffer length, scroll window offset and scroll step divider.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= '0;
         r_offset <= '0;
         r_scroll <= '0;
      end else begin
         if (!scroll_en || w_scroll_step) begin
            r_scroll <= '0;
         end else begin
            r_scroll <= r_scroll + 1'b1;
         end

         if (clear) begin
            r_count  <= '0;
            r_offset <= '0;
         end else begin
            if (w_wr_accept) begin
               r_count <= r_count + 1'b1;
            end
            // Step decisions use the length as it stood before this cycle's
            // write, so a newly appended character joins at the next step.
            if (!scroll_en) begin
               r_offset <= '0;
            end else if (w_scroll_step) begin
               if (r_count > ND6 && r_offset < (r_count - ND6)) begin
                  r_offset <= r_offset + 1'b1;
               end else begin
                  r_offset <= '0;
               end
            end
         end
      end
   end

   // Digit multiplex: hold each digit for REFRESH_DIV cycles, then advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_refresh <= '0;
         r_p       <= '0;
      end else if (r_refresh == REF_LAST) begin
         r_refresh <= '0;
         r_p       <= (r_p == P_LAST) ? '0 : r_p + 1'b1;
      end else begin
         r_refresh <= r_refresh + 1'b1;
      end
   end

   // Character code to active-low {g,f,e,d,c,b,a} pattern.
   always_comb begin
      w_glyph = BLANK;
      case (w_code)
         5'd0:    w_glyph = 7'h08;
         5'd1:    w_glyph = 7'h03;
         5'd2:    w_glyph = 7'h46;
         5'd3:    w_glyph = 7'h21;
         5'd4:    w_glyph = 7'h06;
         5'd5:    w_glyph = 7'h0E;
         5'd6:    w_glyph = 7'h10;
         5'd7:    w_glyph = 7'h0B;
         5'd8:    w_glyph = 7'h79;
         5'd9:    w_glyph = 7'h71;
         5'd10:   w_glyph = 7'h0E;
         5'd11:   w_glyph = 7'h47;
         5'd12:   w_glyph = 7'h54;
         5'd13:   w_glyph = 7'h15;
         5'd14:   w_glyph = 7'h40;
         5'd15:   w_glyph = 7'h0C;
         5'd16:   w_glyph = 7'h08;
         5'd17:   w_glyph = 7'h1F;
         5'd18:   w_glyph = 7'h12;
         5'd19:   w_glyph = 7'h07;
         5'd20:   w_glyph = 7'h41;
         5'd21:   w_glyph = 7'h61;
         5'd22:   w_glyph = 7'h50;
         5'd23:   w_glyph = 7'h37;
         5'd24:   w_glyph = 7'h11;
         5'd25:   w_glyph = 7'h24;
         default: w_glyph = BLANK;
      endcase
   end

   // One-hot-low anode pattern for the current digit position.
   always_comb begin
      w_an_next      = '1;
      w_an_next[r_p] = 1'b0;
   end

   // Registered display outputs; everything dark while in reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg <= BLANK;
         r_an  <= '1;
      end else begin
         r_seg <= w_blank ? BLANK : w_glyph;
         r_an  <= w_an_next;
      end
   end

endmodule

// File: tb/tb_seven_seg_scroll_driver.sv
// Scoreboard bench for seven_seg_scroll_driver (4 digits, 8 entries,
// refresh every 4 cycles, scroll every 32 cycles).
module tb_seven_seg_scroll_driver;

   localparam int ND = 4;
   localparam int BD = 8;
   localparam int RD = 4;
   localparam int SD = 32;

   localparam int K_AN   = 0;
   localparam int K_SEG  = 1;
   localparam int K_CNT  = 2;
   localparam int K_FULL = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [4:0]    wr_char = '0;
   logic          clear = 1'b0;
   logic          scroll_en = 1'b0;
   logic          buf_full;
   logic [5:0]    char_count;
   logic [6:0]    seg;
   logic [ND-1:0] an;

   seven_seg_scroll_driver #(
      .NUM_DIGITS (ND),
      .BUF_DEPTH  (BD),
      .REFRESH_DIV(RD),
      .SCROLL_DIV (SD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_char   (wr_char),
      .clear     (clear),
      .scroll_en (scroll_en),
      .buf_full  (buf_full),
      .char_count(char_count),
      .seg       (seg),
      .an        (an)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          when;
      int          kind;
      string       name;
      logic [31:0] exp;
   } item_t;

   item_t       sb[$];
   int          n_pass = 0;
   int          n_total = 0;
   int          rel_cyc = 0;
   logic [6:0]  gtab [32];

   // Monitor: compare every expectation due at this cycle against the DUT.
   always @(negedge clk) begin
      item_t       it;
      logic [31:0] act;
      while (sb.size() > 0 && sb[0].when <= cyc) begin
         it = sb.pop_front();
         case (it.kind)
            K_AN:    act = 32'(an);
            K_SEG:   act = 32'(seg);
            K_CNT:   act = 32'(char_count);
            default: act = 32'(buf_full);
         endcase
         n_total++;
         if (act === it.exp) n_pass++;
         else $display("FAIL %s: got %0h expected %0h (cycle %0d)", it.name, act, it.exp, cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string name, input int kind, input logic [31:0] exp);
      item_t it;
      it.when = cyc;
      it.kind = kind;
      it.name = name;
      it.exp  = exp;
      sb.push_back(it);
   endtask

   // Digit shown at cycle c: one step per 4 cycles since reset release.
   function automatic int dig(input int c);
      return ((c - rel_cyc - 1) / RD) % ND;
   endfunction

   task automatic chk_disp(input string name, input logic [6:0] s);
      logic [3:0] a;
      a = ~(4'b0001 << dig(cyc));
      push({name, "_an"}, K_AN, 32'(a));
      push({name, "_seg"}, K_SEG, 32'(s));
   endtask

   task automatic do_reset(input string name);
      rst       = 1'b1;
      wr_en     = 1'b1;
      wr_char   = 5'd3;
      clear     = 1'b0;
      scroll_en = 1'b0;
      repeat (3) begin
         tick();
         push({name, "_rst_an"}, K_AN, 32'hF);
         push({name, "_rst_seg"}, K_SEG, 32'h7F);
      end
      rst     = 1'b0;
      wr_en   = 1'b0;
      rel_cyc = cyc;
      tick();
      chk_disp({name, "_first"}, 7'h7F);
      push({name, "_cnt0"}, K_CNT, 32'd0);
      push({name, "_full0"}, K_FULL, 32'd0);
   endtask

   task automatic write_char(input logic [4:0] c);
      wr_en   = 1'b1;
      wr_char = c;
      tick();
      wr_en   = 1'b0;
   endtask

   initial begin
      logic [4:0] help [4];
      int         d;
      int         off;
      int         s0;
      int         t0;

      gtab = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h10, 7'h0B,
               7'h79, 7'h71, 7'h0E, 7'h47, 7'h54, 7'h15, 7'h40, 7'h0C,
               7'h08, 7'h1F, 7'h12, 7'h07, 7'h41, 7'h61, 7'h50, 7'h37,
               7'h11, 7'h24, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      help = '{5'd7, 5'd4, 5'd11, 5'd15};

      // Idle after reset: anodes walk, segments stay dark.
      do_reset("idle");
      repeat (20) begin
         tick();
         chk_disp("idle", 7'h7F);
      end

      // Static text HELP.
      do_reset("help");
      for (int i = 0; i < 4; i++) write_char(help[i]);
      push("help_cnt", K_CNT, 32'd4);
      push("help_full", K_FULL, 32'd0);
      tick();
      repeat (16) begin
         tick();
         chk_disp("help", gtab[help[dig(cyc)]]);
      end
      // Exactly NUM_DIGITS characters: scrolling leaves the window in place.
      scroll_en = 1'b1;
      repeat (72) begin
         tick();
         chk_disp("help_scr", gtab[help[dig(cyc)]]);
      end
      scroll_en = 1'b0;

      // Overfill: ninth write is dropped.
      do_reset("full");
      for (int i = 0; i < 9; i++) begin
         write_char(5'(i));
         push("full_cnt", K_CNT, 32'((i + 1 > BD) ? BD : i + 1));
         push("full_flag", K_FULL, 32'((i + 1 >= BD) ? 1 : 0));
      end
      tick();
      repeat (16) begin
         tick();
         chk_disp("full_disp", gtab[dig(cyc)]);
      end

      // Scroll A..F: offsets 0,1,2,0 every 32 cycles, then leave scroll mode.
      do_reset("scr");
      for (int i = 0; i < 6; i++) write_char(5'(i));
      push("scr_cnt", K_CNT, 32'd6);
      tick();
      scroll_en = 1'b1;
      s0 = cyc;
      t0 = s0 + 70;
      repeat (90) begin
         tick();
         off = (cyc <= t0 + 1) ? ((cyc - 1 - s0) / SD) % 3 : 0;
         d = dig(cyc);
         chk_disp("scr", gtab[off + d]);
         if (cyc == t0) scroll_en = 1'b0;
      end
      // Re-enter scroll mode: divider restarts from zero.
      scroll_en = 1'b1;
      s0 = cyc;
      repeat (70) begin
         tick();
         off = ((cyc - 1 - s0) / SD) % 3;
         chk_disp("scr2", gtab[off + dig(cyc)]);
      end
      // Reset with offset at 2.
      do_reset("scrrst");

      // Clear and write together with five stored characters.
      for (int i = 0; i < 5; i++) write_char(5'(i));
      push("clr_cnt5", K_CNT, 32'd5);
      tick();
      clear   = 1'b1;
      wr_en   = 1'b1;
      wr_char = 5'd25;
      tick();
      clear = 1'b0;
      wr_en = 1'b0;
      push("clr_cnt", K_CNT, 32'd0);
      push("clr_full", K_FULL, 32'd0);
      repeat (16) begin
         tick();
         chk_disp("clr", 7'h7F);
      end
      // Next write lands at index 0 again.
      write_char(5'd25);
      push("clr_wr_cnt", K_CNT, 32'd1);
      tick();
      repeat (16) begin
         tick();
         chk_disp("clr_wr", (dig(cyc) == 0) ? gtab[25] : 7'h7F);
      end

      for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
      if (sb.size() > 0) begin
         $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
         n_total += sb.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
